// File: rtl/neural_uplink_framer_if.sv
// Uplink framer bus: packet-word input (no backpressure) plus byte-serial
// telemetry output with a valid/ready handshake.
interface neural_uplink_framer_if #(
  parameter int PKT_W = 32
);
  logic             in_valid;
  logic [PKT_W-1:0] in_data;
  logic             tx_ready;
  logic             tx_valid;
  logic [7:0]       tx_data;
  logic             tx_sof;
  logic             tx_eof;

  modport master (
    output in_valid, in_data, tx_ready,
    input  tx_valid, tx_data, tx_sof, tx_eof
  );

  modport slave (
    input  in_valid, in_data, tx_ready,
    output tx_valid, tx_data, tx_sof, tx_eof
  );
endinterface

// File: rtl/neural_uplink_framer.sv
// Buffers {channel, timestamp, sample} words and packs them into byte-serial
// frames: A5 5A seq n payload chk, with an idle flush for short frames.
module neural_uplink_framer #(
  parameter int SAMPLE_W  = 12,
  parameter int TS_W      = 16,
  parameter int CH_W      = 4,
  parameter int BUF_DEPTH = 16,
  parameter int FRAME_LEN = 8,
  parameter int FLUSH_CYC = 64
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  neural_uplink_framer_if.slave up,
  output logic [7:0]            drop_cnt,
  output logic                  overflow
);
  // state   | meaning
  // IDLE    | waiting for FRAME_LEN words or flush timeout
  // SYNC0   | presenting 0xA5 (sof)
  // SYNC1   | presenting 0x5A
  // SEQ     | presenting sequence number
  // CNT     | presenting word count n
  // PAYLOAD | presenting word bytes, MSB first
  // CHK     | presenting XOR checksum (eof)

  localparam int PKT_W = SAMPLE_W + TS_W + CH_W;
  localparam int BPW   = PKT_W / 8;
  localparam int AW    = $clog2(BUF_DEPTH);
  localparam int CW    = AW + 1;
  localparam int BIW   = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int TW    = $clog2(FLUSH_CYC + 2);

  localparam logic [CW-1:0]  DEPTH_C = CW'(BUF_DEPTH);
  localparam logic [CW-1:0]  FLEN_C  = CW'(FRAME_LEN);
  localparam logic [TW-1:0]  FLUSH_C = TW'(FLUSH_CYC);
  localparam logic [BIW-1:0] LAST_B  = BIW'(BPW - 1);

  if (PKT_W % 8 != 0) begin : g_pkt_w_chk
    $error("PKT_W must be a multiple of 8");
  end
  if (BUF_DEPTH < 2 || (BUF_DEPTH & (BUF_DEPTH - 1)) != 0) begin : g_depth_chk
    $error("BUF_DEPTH must be a power of 2 and at least 2");
  end
  if (FRAME_LEN < 1 || FRAME_LEN > BUF_DEPTH || FRAME_LEN > 255) begin : g_flen_chk
    $error("FRAME_LEN must be in 1..min(BUF_DEPTH,255)");
  end

  typedef enum logic [2:0] {IDLE, SYNC0, SYNC1, SEQ, CNT, PAYLOAD, CHK} state_t;

  state_t           state_q, state_d;
  logic [PKT_W-1:0] mem_q [BUF_DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;
  logic             overflow_q, overflow_d;
  logic [7:0]       seq_q, seq_d;
  logic [7:0]       n_q, n_d;
  logic [7:0]       word_idx_q, word_idx_d;
  logic [BIW-1:0]   byte_idx_q, byte_idx_d;
  logic [7:0]       chk_q, chk_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic             tx_valid_q, tx_valid_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_sof_q, tx_sof_d;
  logic             tx_eof_q, tx_eof_d;

  logic       xfer, has_room, push, pop, last_byte, full, flush_fire, launch;
  logic [7:0] chk_next;
  logic [AW-1:0] rd_ptr_nxt;

  function automatic logic [7:0] word_byte(logic [PKT_W-1:0] w, logic [BIW-1:0] idx);
    logic [PKT_W-1:0] sh;
    sh = w >> (8 * (BPW - 1 - int'(idx)));
    return sh[7:0];
  endfunction

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    drop_cnt_d = drop_cnt_q;
    overflow_d = overflow_q;
    seq_d      = seq_q;
    n_d        = n_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    chk_d      = chk_q;
    tmr_d      = '0;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    tx_sof_d   = tx_sof_q;
    tx_eof_d   = tx_eof_q;

    xfer       = tx_valid_q && up.tx_ready;
    has_room   = count_q < DEPTH_C;
    push       = up.in_valid && has_room;
    pop        = 1'b0;
    last_byte  = byte_idx_q == LAST_B;
    full       = count_q >= FLEN_C;
    flush_fire = (FLUSH_CYC != 0) && (tmr_q >= FLUSH_C);
    launch     = 1'b0;
    chk_next   = chk_q ^ tx_data_q;
    rd_ptr_nxt = rd_ptr_q + 1'b1;

    // A word seen while full is lost even if a pop happens on the same edge.
    if (up.in_valid && !has_room) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    end

    unique case (state_q)
      IDLE: begin
        if (full || flush_fire) begin
          launch     = 1'b1;
          state_d    = SYNC0;
          n_d        = full ? 8'(FRAME_LEN) : 8'(count_q);
          word_idx_d = '0;
          byte_idx_d = '0;
          chk_d      = '0;
          tx_valid_d = 1'b1;
          tx_data_d  = 8'hA5;
          tx_sof_d   = 1'b1;
        end
      end
      SYNC0: if (xfer) begin
        state_d   = SYNC1;
        tx_data_d = 8'h5A;
        tx_sof_d  = 1'b0;
      end
      SYNC1: if (xfer) begin
        state_d   = SEQ;
        tx_data_d = seq_q;
      end
      SEQ: if (xfer) begin
        state_d   = CNT;
        tx_data_d = n_q;
        chk_d     = chk_next;
      end
      CNT: if (xfer) begin
        state_d   = PAYLOAD;
        tx_data_d = word_byte(mem_q[rd_ptr_q], '0);
        chk_d     = chk_next;
      end
      PAYLOAD: if (xfer) begin
        chk_d = chk_next;
        if (last_byte) begin
          pop        = 1'b1;
          byte_idx_d = '0;
          if (word_idx_q == n_q - 8'd1) begin
            state_d   = CHK;
            tx_data_d = chk_next;
            tx_eof_d  = 1'b1;
          end else begin
            word_idx_d = word_idx_q + 8'd1;
            tx_data_d  = word_byte(mem_q[rd_ptr_nxt], '0);
          end
        end else begin
          byte_idx_d = byte_idx_q + 1'b1;
          tx_data_d  = word_byte(mem_q[rd_ptr_q], byte_idx_q + 1'b1);
        end
      end
      CHK: if (xfer) begin
        state_d    = IDLE;
        tx_valid_d = 1'b0;
        tx_eof_d   = 1'b0;
        seq_d      = seq_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_nxt;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Flush timer only runs while a partial frame sits idle in the buffer.
    if (FLUSH_CYC != 0 && state_q == IDLE && !launch && count_q != '0 && !full)
      tmr_d = tmr_q + 1'b1;
  end

  always_ff @(posedge sys_clk) begin
    if (push) mem_q[wr_ptr_q] <= up.in_data;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
      seq_q      <= '0;
      n_q        <= '0;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      chk_q      <= '0;
      tmr_q      <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      tx_sof_q   <= 1'b0;
      tx_eof_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      drop_cnt_q <= drop_cnt_d;
      overflow_q <= overflow_d;
      seq_q      <= seq_d;
      n_q        <= n_d;
      word_idx_q <= word_idx_d;
      byte_idx_q <= byte_idx_d;
      chk_q      <= chk_d;
      tmr_q      <= tmr_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      tx_sof_q   <= tx_sof_d;
      tx_eof_q   <= tx_eof_d;
    end
  end

  assign up.tx_valid = tx_valid_q;
  assign up.tx_data  = tx_data_q;
  assign up.tx_sof   = tx_sof_q;
  assign up.tx_eof   = tx_eof_q;
  assign drop_cnt    = drop_cnt_q;
  assign overflow    = overflow_q;
endmodule

// File: tb/tb_neural_uplink_framer.sv
// Bench for neural_uplink_framer: queue-based reference model of the buffer,
// frame builder from the frame-format rules, directed plus random stimulus.
module tb_neural_uplink_framer;
  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic [7:0] drop_cnt;
  logic       overflow;

  neural_uplink_framer_if #(.PKT_W(32)) bus ();

  neural_uplink_framer dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .up        (bus),
    .drop_cnt  (drop_cnt),
    .overflow  (overflow)
  );

  always #5 sys_clk = ~sys_clk;

  int          checks = 0;
  int          errors = 0;
  int          ready_mode = 1;  // 0 low, 1 high, 2 random
  logic [31:0] wr_q[$];
  logic [31:0] exp_words[$];
  int          exp_drop = 0;
  logic [7:0]  exp_seq = 8'h00;
  logic [7:0]  cap_data[$];
  logic        cap_sof[$];
  logic        cap_eof[$];
  bit          stall_prev = 1'b0;
  logic [7:0]  prev_data;
  logic        prev_sof, prev_eof;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One cycle: observe outputs at the falling edge, then drive the inputs
  // that the next rising edge will see.
  task automatic step();
    logic [31:0] w;
    @(negedge sys_clk);
    if (stall_prev) begin
      check("stall_valid", 32'(bus.tx_valid), 32'd1);
      check("stall_data",  32'(bus.tx_data),  32'(prev_data));
      check("stall_sof",   32'(bus.tx_sof),   32'(prev_sof));
      check("stall_eof",   32'(bus.tx_eof),   32'(prev_eof));
    end
    case (ready_mode)
      0:       bus.tx_ready = 1'b0;
      1:       bus.tx_ready = 1'b1;
      default: bus.tx_ready = 1'($urandom_range(0, 1));
    endcase
    stall_prev = bus.tx_valid && !bus.tx_ready;
    prev_data  = bus.tx_data;
    prev_sof   = bus.tx_sof;
    prev_eof   = bus.tx_eof;
    if (bus.tx_valid && bus.tx_ready) begin
      cap_data.push_back(bus.tx_data);
      cap_sof.push_back(bus.tx_sof);
      cap_eof.push_back(bus.tx_eof);
    end
    if (wr_q.size() > 0) begin
      w = wr_q.pop_front();
      bus.in_valid = 1'b1;
      bus.in_data  = w;
      if (exp_words.size() < 16) exp_words.push_back(w);
      else if (exp_drop < 255) exp_drop++;
    end else begin
      bus.in_valid = 1'b0;
      bus.in_data  = $urandom();
    end
  endtask

  task automatic run(int n);
    repeat (n) step();
  endtask

  task automatic collect_frame(string tag, int max_bytes, int budget, output int sof_step);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    sof_step = -1;
    cap_data.delete();
    cap_sof.delete();
    cap_eof.delete();
    while (!done && n < budget) begin
      step();
      n++;
      if (cap_data.size() == 1 && sof_step < 0) sof_step = n;
      if (cap_eof.size() > 0 && cap_eof[$]) done = 1'b1;
      if (cap_data.size() >= max_bytes) done = 1'b1;
    end
    check({tag, "_timeout"}, 32'(done), 32'd1);
  endtask

  // Expected frame from the format rules: sync, seq, n, words MSB byte first, XOR.
  task automatic verify_frame(string tag, int n);
    logic [7:0]  exp_b[$];
    logic [7:0]  x;
    logic [7:0]  b8;
    logic [31:0] w;
    exp_b.push_back(8'hA5);
    exp_b.push_back(8'h5A);
    exp_b.push_back(exp_seq);
    exp_b.push_back(8'(n));
    x = exp_seq ^ 8'(n);
    for (int i = 0; i < n; i++) begin
      w = exp_words.pop_front();
      for (int b = 3; b >= 0; b--) begin
        b8 = 8'(w >> (8 * b));
        exp_b.push_back(b8);
        x = x ^ b8;
      end
    end
    exp_b.push_back(x);
    check({tag, "_len"}, 32'(cap_data.size()), 32'(exp_b.size()));
    for (int i = 0; i < exp_b.size() && i < cap_data.size(); i++) begin
      check($sformatf("%s_byte%0d", tag, i), 32'(cap_data[i]), 32'(exp_b[i]));
      check($sformatf("%s_sof%0d", tag, i), 32'(cap_sof[i]), 32'(i == 0));
      check($sformatf("%s_eof%0d", tag, i), 32'(cap_eof[i]), 32'(i == exp_b.size() - 1));
    end
    exp_seq = exp_seq + 8'd1;
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.tx_ready = 1'b0;
    sys_rst_n    = 1'b0;
    repeat (3) @(negedge sys_clk);
    check("rst_valid", 32'(bus.tx_valid), 32'd0);
    check("rst_data",  32'(bus.tx_data),  32'd0);
    check("rst_sof",   32'(bus.tx_sof),   32'd0);
    check("rst_eof",   32'(bus.tx_eof),   32'd0);
    check("rst_drop",  32'(drop_cnt),     32'd0);
    check("rst_ovf",   32'(overflow),     32'd0);
    sys_rst_n = 1'b1;

    // 1: eight fixed words, always ready
    ready_mode = 1;
    for (int k = 1; k <= 8; k++) wr_q.push_back(32'h1000_0000 + 32'(k));
    collect_frame("t1", 1000, 100, lat);
    check("t1_launch_lat", 32'(lat), 32'd10);
    if (cap_data.size() == 37) check("t1_chk_lit", 32'(cap_data[36]), 32'h00);
    verify_frame("t1", 8);

    // 2: same words, random ready
    ready_mode = 2;
    for (int k = 1; k <= 8; k++) wr_q.push_back(32'h1000_0000 + 32'(k));
    collect_frame("t2", 1000, 400, lat);
    verify_frame("t2", 8);

    // 3: three words then idle -> flushed short frame
    ready_mode = 1;
    wr_q.push_back(32'h2000_00AA);
    wr_q.push_back(32'h2000_00BB);
    wr_q.push_back(32'h2000_00CC);
    collect_frame("t3", 1000, 200, lat);
    check("t3_flush_lat", 32'(lat >= 62 && lat <= 72), 32'd1);
    verify_frame("t3", 3);

    // 4: stalled uplink, 20 writes into a 16-deep buffer
    ready_mode = 0;
    for (int k = 1; k <= 20; k++) wr_q.push_back(32'h4000_0000 + 32'(k));
    run(25);
    check("t4_drop", 32'(drop_cnt), 32'(exp_drop));
    check("t4_ovf",  32'(overflow), 32'd1);
    ready_mode = 1;
    collect_frame("t4a", 1000, 100, lat);
    verify_frame("t4a", 8);
    collect_frame("t4b", 1000, 100, lat);
    verify_frame("t4b", 8);

    // 5: 257 full frames of random words, sequence number wraps
    for (int f = 0; f < 257; f++) begin
      ready_mode = (f % 2 == 0) ? 1 : 2;
      for (int k = 0; k < 8; k++) wr_q.push_back($urandom());
      collect_frame($sformatf("t5f%0d", f), 1000, 400, lat);
      verify_frame($sformatf("t5f%0d", f), 8);
    end
    ready_mode = 0;
    for (int k = 0; k < 316; k++) wr_q.push_back($urandom());
    run(330);
    check("t5_drop_sat", 32'(drop_cnt), 32'(exp_drop));
    check("t5_ovf",      32'(overflow), 32'd1);

    // 6: reset during payload
    ready_mode = 1;
    collect_frame("t6_part", 7, 60, lat);
    @(posedge sys_clk);
    #2 sys_rst_n = 1'b0;
    #1;
    check("t6_valid", 32'(bus.tx_valid), 32'd0);
    check("t6_sof",   32'(bus.tx_sof),   32'd0);
    check("t6_drop",  32'(drop_cnt),     32'd0);
    check("t6_ovf",   32'(overflow),     32'd0);
    exp_words.delete();
    exp_seq    = 8'h00;
    exp_drop   = 0;
    stall_prev = 1'b0;
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) wr_q.push_back(32'h6000_0000 + 32'(k));
    collect_frame("t6_post", 1000, 100, lat);
    verify_frame("t6_post", 8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
